// File: rtl/conv_pe_pkg.sv
// Shared types and constants for the 1-D convolution processing element.
package conv_pe_pkg;

    localparam logic [1:0] TAG_START = 2'b10;
    localparam logic [1:0] TAG_MID   = 2'b00;
    localparam logic [1:0] TAG_END   = 2'b01;
    localparam logic [1:0] TAG_LAST  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        EMIT,
        DROP
    } state_t;

    // Psums produced per filter for one row.
    function automatic int num_outputs(input int row_len, input int filter_size, input int stride);
        if (stride <= 0 || filter_size <= 0 || row_len < filter_size) return 0;
        return (row_len - filter_size) / stride + 1;
    endfunction

endpackage

// File: rtl/conv_pe_mac.sv
// Single multiply-accumulate lane; the first tap of a psum restarts the sum from zero.
module conv_pe_mac #(
    parameter int DATA_W = 16,
    parameter int PSUM_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              first,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [PSUM_W-1:0] acc
);

    logic [PSUM_W-1:0] prod;
    logic [PSUM_W-1:0] base;

    // Only the low PSUM_W bits of the product matter under modulo arithmetic.
    assign prod = PSUM_W'(a) * PSUM_W'(b);
    assign base = first ? '0 : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= base + prod;
        end
    end

endmodule

// File: rtl/conv_pe_multifilter.sv
// 1-D convolution PE: buffers a tagged IFMap row, then emits one psum per window per active filter.
module conv_pe_multifilter
    import conv_pe_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int PSUM_W         = 16,
    parameter int IFMAP_SPAD_ROW = 8,
    parameter int FILTER_MAX     = 4,
    parameter int NUM_FILTERS    = 2,
    parameter int STRIDE_W       = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [$clog2(FILTER_MAX+1)-1:0]    cfg_filter_size,
    input  logic [STRIDE_W-1:0]                cfg_stride,
    input  logic [$clog2(NUM_FILTERS+1)-1:0]   cfg_num_filters,
    input  logic                               filter_wen,
    input  logic [$clog2(NUM_FILTERS)-1:0]     filter_sel,
    input  logic [$clog2(FILTER_MAX)-1:0]      filter_addr,
    input  logic [DATA_W-1:0]                  filter_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_W+1:0]                  in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [PSUM_W-1:0]                  out_psum,
    output logic [$clog2(NUM_FILTERS)-1:0]     out_filter,
    output logic                               busy,
    output logic                               done,
    output logic                               cfg_err,
    output logic                               row_ovf
);

    localparam int FS_W   = $clog2(FILTER_MAX + 1);
    localparam int NF_W   = $clog2(NUM_FILTERS + 1);
    localparam int FSEL_W = $clog2(NUM_FILTERS);
    localparam int FA_W   = $clog2(FILTER_MAX);
    localparam int ADDR_W = $clog2(IFMAP_SPAD_ROW);
    localparam int LEN_W  = $clog2(IFMAP_SPAD_ROW + 1);
    localparam int CW     = 16;

    state_t              state;
    logic [FS_W-1:0]     fsize;
    logic [STRIDE_W-1:0] stride;
    logic [NF_W-1:0]     nf;
    logic [ADDR_W-1:0]   ptr;
    logic [LEN_W-1:0]    row_len;
    logic                frame_end;
    logic                drop;
    logic [ADDR_W-1:0]   w;
    logic [FSEL_W-1:0]   f;
    logic [FA_W-1:0]     k;

    logic [DATA_W-1:0] spad [IFMAP_SPAD_ROW];
    logic [DATA_W-1:0] filt [NUM_FILTERS][FILTER_MAX];

    logic [1:0]        tag;
    logic [DATA_W-1:0] val;
    logic [ADDR_W-1:0] load_ptr;
    logic [LEN_W-1:0]  load_len;
    logic              is_end;
    logic              ovf_hit;
    logic              cfg_ok;
    logic              last_tap;
    logic              more_filt;
    logic              next_fits;
    logic [ADDR_W-1:0] tap_idx;

    assign tag      = in_data[DATA_W +: 2];
    assign val      = in_data[DATA_W-1:0];
    // A row without a leading start tag still begins at position 0 because ptr is cleared on LOAD entry.
    assign load_ptr = (tag == TAG_START) ? '0 : ptr;
    assign load_len = LEN_W'(load_ptr) + LEN_W'(1);
    assign is_end   = (tag == TAG_END) || (tag == TAG_LAST);
    assign ovf_hit  = !is_end && (load_ptr == ADDR_W'(IFMAP_SPAD_ROW - 1));

    assign cfg_ok = (cfg_filter_size != '0)
                 && (CW'(cfg_filter_size) <= CW'(FILTER_MAX))
                 && (cfg_stride != '0)
                 && (cfg_num_filters != '0)
                 && (CW'(cfg_num_filters) <= CW'(NUM_FILTERS));

    assign last_tap  = (CW'(k) + CW'(1)) == CW'(fsize);
    assign more_filt = (CW'(f) + CW'(1)) < CW'(nf);
    assign next_fits = (CW'(w) + CW'(stride) + CW'(fsize)) <= CW'(row_len);
    assign tap_idx   = w + ADDR_W'(k);

    assign in_ready = (state == LOAD) || (state == DROP);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (state == IDLE && filter_wen) begin
            filt[filter_sel][filter_addr] <= filter_data;
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            spad[load_ptr] <= val;
        end
    end

    conv_pe_mac #(
        .DATA_W (DATA_W),
        .PSUM_W (PSUM_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (state == MAC),
        .first (k == '0),
        .a     (spad[tap_idx]),
        .b     (filt[f][k]),
        .acc   (out_psum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fsize      <= '0;
            stride     <= '0;
            nf         <= '0;
            ptr        <= '0;
            row_len    <= '0;
            frame_end  <= 1'b0;
            drop       <= 1'b0;
            w          <= '0;
            f          <= '0;
            k          <= '0;
            out_valid  <= 1'b0;
            out_filter <= '0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            row_ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!cfg_ok) begin
                            cfg_err <= 1'b1;
                        end else begin
                            cfg_err   <= 1'b0;
                            fsize     <= cfg_filter_size;
                            stride    <= cfg_stride;
                            nf        <= cfg_num_filters;
                            ptr       <= '0;
                            drop      <= 1'b0;
                            frame_end <= 1'b0;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        ptr <= load_ptr + ADDR_W'(1);
                        if (is_end || ovf_hit) begin
                            row_len   <= load_len;
                            frame_end <= (tag == TAG_LAST);
                            drop      <= ovf_hit;
                            w         <= '0;
                            f         <= '0;
                            k         <= '0;
                            if (ovf_hit) row_ovf <= 1'b1;
                            // Row shorter than the filter: no windows, finish the row right here.
                            if (CW'(load_len) < CW'(fsize)) begin
                                ptr  <= '0;
                                drop <= 1'b0;
                                if (tag == TAG_LAST) begin
                                    state <= IDLE;
                                    done  <= 1'b1;
                                end else if (ovf_hit) begin
                                    state <= DROP;
                                end else begin
                                    state <= LOAD;
                                end
                            end else begin
                                state <= MAC;
                            end
                        end
                    end
                end
                MAC: begin
                    if (last_tap) begin
                        state      <= EMIT;
                        out_valid  <= 1'b1;
                        out_filter <= f;
                    end else begin
                        k <= k + FA_W'(1);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        k         <= '0;
                        if (more_filt) begin
                            f     <= f + FSEL_W'(1);
                            state <= MAC;
                        end else if (next_fits) begin
                            w     <= w + ADDR_W'(stride);
                            f     <= '0;
                            state <= MAC;
                        end else begin
                            ptr  <= '0;
                            drop <= 1'b0;
                            if (frame_end) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else if (drop) begin
                                state <= DROP;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
                end
                DROP: begin
                    if (in_valid && is_end) begin
                        ptr <= '0;
                        if (tag == TAG_LAST) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/conv_pe_multifilter.md
Name: conv_pe_multifilter

Overview:
Next-generation 1-D convolution processing element. It streams tagged IFMap rows into a row scratchpad and holds up to NUM_FILTERS filter rows of configurable length. For every stride position it computes one partial sum per active filter, one MAC per cycle, and emits the psums on a valid/ready port. Frame-level tags allow back-to-back rows without a new start pulse.

Parameters:
DATA_W, 16, IFMap/filter element width (unsigned)
PSUM_W, 16, psum/accumulator width; arithmetic is modulo 2^PSUM_W
IFMAP_SPAD_ROW, 8, max IFMap row length
FILTER_MAX, 4, max filter length
NUM_FILTERS, 2, filter scratchpad count
STRIDE_W, 3, stride config width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse in IDLE; latches config
cfg_filter_size  in  $clog2(FILTER_MAX+1)  filter length, 1..FILTER_MAX
cfg_stride  in  STRIDE_W  stride, >=1
cfg_num_filters  in  $clog2(NUM_FILTERS+1)  active filters, 1..NUM_FILTERS
filter_wen  in  1  filter write, honoured only in IDLE
filter_sel  in  $clog2(NUM_FILTERS)  filter index
filter_addr  in  $clog2(FILTER_MAX)  tap index
filter_data  in  DATA_W  tap value
in_valid  in  1  IFMap word valid
in_ready  out  1  IFMap word accepted when valid&ready
in_data  in  DATA_W+2  {tag[1:0], value}; tag 10=row start, 00=mid, 01=row end, 11=row end+frame end
out_valid  out  1  psum valid
out_ready  in  1  psum consumer ready
out_psum  out  PSUM_W  psum
out_filter  out  $clog2(NUM_FILTERS)  filter index of out_psum
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on return to IDLE
cfg_err  out  1  sticky: illegal config on start
row_ovf  out  1  sticky: row exceeded IFMAP_SPAD_ROW

Behaviour:
- Reset values: state IDLE; all outputs 0, including the sticky flags. Filter scratchpad contents are not reset. Reset asserted mid-frame aborts immediately and discards any pending psum.
- IDLE: in_ready=0. Filter writes land here. On start, the block checks config; filter_size 0 or >FILTER_MAX, stride 0, or num_filters 0 or >NUM_FILTERS sets cfg_err and the block stays in IDLE. Otherwise it latches config, clears cfg_err, and goes to LOAD. start together with filter_wen: the write lands and is used by the frame. start outside IDLE is ignored.
- LOAD: in_ready=1. Tag 10 writes the word at pointer 0, and pointer becomes 1. Tags 00/01/11 write at the pointer and increment it; a word arriving before any tag 10 behaves as a tag 10. Tag 01/11 sets row_len=pointer+1 and records frame_end (tag 11); next state is MAC.
- Overflow: if a mid word fills position IFMAP_SPAD_ROW-1, row_len=IFMAP_SPAD_ROW, row_ovf is set, and the block goes to MAC with a drop flag. After that row, it enters DROP.
- DROP: in_ready=1; words are discarded through the next 01/11 tag. Tag 11 leads to IDLE with a done pulse; tag 01 leads to LOAD.
- MAC: window w starts at 0; filter f runs 0..num_filters-1. There is one cycle per tap k: acc = (k==0 ? 0 : acc) + ifmap[w+k]*filter[f][k], truncated to PSUM_W. After tap filter_size-1, the next state is EMIT.
- Short row: if row_len < filter_size, no MAC is performed and the row ends directly (see end-of-row rule).
- EMIT: out_valid=1, out_psum=acc, out_filter=f. These are held stable until out_ready. On handshake:
  - if more filters remain, f++ and go to MAC;
  - else if w+stride+filter_size <= row_len, w+=stride, f=0, and go to MAC;
  - else end of row.
- End of row: frame_end leads to IDLE with a done pulse; otherwise the next state is LOAD (or DROP if the drop flag is set).
- Throughput: filter_size+1 cycles per psum with out_ready=1. Ordering is window-major, filter-minor. Outputs per filter = floor((row_len-filter_size)/stride)+1.

Decomposition:
- Package conv_pe_pkg holds:
  - tag constants TAG_START/TAG_MID/TAG_END/TAG_LAST;
  - state enum {IDLE, LOAD, MAC, EMIT, DROP};
  - a helper function computing output count.
- Sub-module conv_pe_mac: DATA_W×DATA_W multiply plus PSUM_W accumulate register with clear-on-first-tap and enable.

Test Plan:
- Filter0={1,2,3}, size 3, stride 2, 1 filter; row 1..7 (1 tagged 10, 7 tagged 11) -> psums 14, 26, 38, then done pulse, busy=0.
- Same row with filter1={9,8,7} and num_filters=2 -> sequence (14,f0), (46,f1), (26,f0), (94,f1), (38,f0), (142,f1).
- Two rows {4,5,6} tag 01, then {1,2,3} tag 11; filter {1,1}, stride 1 -> 9, 11, 3, 5; a single done after 5.
- Backpressure: out_ready low 5 cycles during first EMIT -> out_valid and psum=14 held stable, no loss. Row {1,2} tag 11 with size 3 -> no outputs, done pulse.
- Illegal config: start with stride 0 -> cfg_err=1, busy=0. Filter 0xFFFF size 1 with ifmap 0x0002 -> psum 0xFFFE (modulo wrap).
- Overflow: 10 words, 10 tag then eight 00 then 11, IFMAP_SPAD_ROW=8, filter {1} size 1 -> row_ovf=1, 8 psums, 2 words dropped, done. Reset asserted mid-EMIT -> out_valid=0 next cycle, state IDLE.
